// File: rtl/test_status_port.sv
// Picoblaze port-bus test-status peripheral: firmware posts expected/actual check
// values and an end-of-test verdict, which is held on sticky status levels.
module test_status_port #(
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic [7:0]  out_port,
  input  logic        write_strobe,
  input  logic        read_strobe,
  output logic [7:0]  in_port,
  output logic        test_passed,
  output logic        test_failed,
  output logic        test_done,
  output logic [15:0] fail_count,
  output logic        check_valid,
  output logic [7:0]  check_id,
  output logic [7:0]  check_value,
  output logic [7:0]  check_expected,
  output logic        check_mismatch
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DECIDE = 2'd1,
    PASSED = 2'd2,
    FAILED = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [7:0]  expected_reg;
  logic [7:0]  check_count;
  logic [7:0]  rd_data;
  logic        addr_hit;
  logic        wr_ctrl, wr_expected, wr_actual, wr_id;
  logic        terminal;
  logic        do_compare, do_clr;
  logic        mismatch_now;
  logic        unused_read_strobe;

  // Reads have no side effects, so the read qualifier is intentionally unused.
  assign unused_read_strobe = read_strobe;

  assign addr_hit    = write_strobe && (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_ctrl     = addr_hit && (port_id[1:0] == 2'd0);
  assign wr_expected = addr_hit && (port_id[1:0] == 2'd1);
  assign wr_actual   = addr_hit && (port_id[1:0] == 2'd2);
  assign wr_id       = addr_hit && (port_id[1:0] == 2'd3);

  assign terminal     = (state == PASSED) || (state == FAILED);
  assign do_compare   = wr_actual && !terminal;
  assign do_clr       = wr_ctrl && out_port[3] && !terminal;
  assign mismatch_now = (out_port != expected_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (wr_ctrl) begin
          if (out_port[1])      state_next = FAILED;
          else if (out_port[0]) state_next = PASSED;
          else if (out_port[2]) state_next = DECIDE;
        end
      end
      // fail_count is already registered here, so a compare issued on the
      // cycle before the DONE write is counted in the verdict.
      DECIDE:  state_next = (fail_count == '0) ? PASSED : FAILED;
      PASSED:  state_next = PASSED;
      FAILED:  state_next = FAILED;
      default: state_next = RUN;
    endcase
  end

  assign test_passed = (state == PASSED);
  assign test_failed = (state == FAILED);
  assign test_done   = terminal;

  always_ff @(posedge clk) begin
    if (reset) begin
      expected_reg   <= '0;
      check_id       <= '0;
      check_value    <= '0;
      check_expected <= '0;
      check_mismatch <= 1'b0;
      check_valid    <= 1'b0;
      fail_count     <= '0;
      check_count    <= '0;
    end else begin
      check_valid <= 1'b0;
      if (wr_expected) expected_reg <= out_port;
      if (wr_id)       check_id     <= out_port;
      if (do_compare) begin
        check_valid    <= 1'b1;
        check_value    <= out_port;
        check_expected <= expected_reg;
        check_mismatch <= mismatch_now;
        check_count    <= check_count + 8'd1;
        if (mismatch_now && (fail_count != '1)) begin
          fail_count <= fail_count + 16'd1;
        end
      end else if (do_clr) begin
        fail_count  <= '0;
        check_count <= '0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (port_id[7:2] == BASE_ADDR[7:2]) begin
      unique case (port_id[1:0])
        2'd0:    rd_data = {5'b0, test_done, test_failed, test_passed};
        2'd1:    rd_data = fail_count[7:0];
        2'd2:    rd_data = fail_count[15:8];
        default: rd_data = check_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port <= '0;
    end else begin
      in_port <= rd_data;
    end
  end

endmodule

// File: tb/tb_test_status_port.sv
// Directed bench for test_status_port: compares, verdict paths, saturation,
// counter wrap, CLR and reset during DECIDE.
module tb_test_status_port;

  localparam logic [7:0] BASE = 8'hF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  port_id = '0;
  logic [7:0]  out_port = '0;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [7:0]  in_port;
  logic        test_passed, test_failed, test_done;
  logic [15:0] fail_count;
  logic        check_valid;
  logic [7:0]  check_id, check_value, check_expected;
  logic        check_mismatch;

  int checks = 0;
  int failures = 0;
  logic [7:0] rd_val;

  test_status_port #(.BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .read_strobe    (read_strobe),
    .in_port        (in_port),
    .test_passed    (test_passed),
    .test_failed    (test_failed),
    .test_done      (test_done),
    .fail_count     (fail_count),
    .check_valid    (check_valid),
    .check_id       (check_id),
    .check_value    (check_value),
    .check_expected (check_expected),
    .check_mismatch (check_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    write_strobe = 1'b0;
    port_id = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] data);
    @(negedge clk);
    port_id = BASE + {6'd0, off};
    out_port = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id = '0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    port_id = addr;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    data = in_port;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_in_port", in_port, 8'h00);
    check("rst_verdict", {test_passed, test_failed, test_done}, 3'b000);
    check("rst_fail_count", fail_count, 16'h0000);
    check("rst_check_bus", {check_valid, check_mismatch, check_id, check_value, check_expected}, '0);
    for (int i = 0; i < 5; i++) begin
      rd(BASE + 8'(i), rd_val);
      check($sformatf("rst_read_%0d", i), rd_val, 8'h00);
    end

    // Matching compare followed by DONE -> PASSED via DECIDE
    wr(2'd1, 8'h5A);
    wr(2'd3, 8'h03);
    wr(2'd2, 8'h5A);
    check("pass_check_valid", check_valid, 1'b1);
    check("pass_check_fields", {check_mismatch, check_id, check_value, check_expected}, {1'b0, 24'h035A5A});
    @(negedge clk);
    check("pass_valid_pulse", check_valid, 1'b0);
    wr(2'd0, 8'h04);
    check("pass_decide_not_done", test_done, 1'b0);
    @(negedge clk);
    check("pass_verdict", {test_passed, test_failed, test_done}, 3'b101);
    rd(BASE, rd_val);
    check("pass_status", rd_val, 8'h05);
    rd(BASE + 8'd3, rd_val);
    check("pass_check_count", rd_val, 8'h01);

    // Mismatch with DONE on the very next cycle -> FAILED
    do_reset();
    wr(2'd1, 8'h5A);
    @(negedge clk);
    port_id = BASE + 8'd2; out_port = 8'hA5; write_strobe = 1'b1;
    @(negedge clk);
    port_id = BASE; out_port = 8'h04;
    @(negedge clk);
    write_strobe = 1'b0; port_id = '0;
    check("fail_count_one", fail_count, 16'h0001);
    check("fail_mismatch_flag", check_mismatch, 1'b1);
    check("fail_decide_not_done", test_done, 1'b0);
    @(negedge clk);
    check("fail_verdict", {test_passed, test_failed, test_done}, 3'b011);
    rd(BASE, rd_val);
    check("fail_status", rd_val, 8'h06);
    wr(2'd0, 8'h01);
    check("fail_pass_ignored", {test_passed, test_failed}, 2'b01);
    wr(2'd2, 8'h00);
    check("fail_compare_ignored", {check_valid, fail_count}, {1'b0, 16'h0001});
    wr(2'd0, 8'h08);
    check("fail_clr_ignored", fail_count, 16'h0001);

    // FAIL beats PASS in the same CTRL write
    do_reset();
    wr(2'd0, 8'h03);
    check("prio_verdict", {test_passed, test_failed, test_done}, 3'b011);

    // 65535 back-to-back mismatches, then one more: saturation and wrap
    do_reset();
    wr(2'd1, 8'h00);
    @(negedge clk);
    port_id = BASE + 8'd2; out_port = 8'hFF; write_strobe = 1'b1;
    repeat (65535) @(negedge clk);
    write_strobe = 1'b0; port_id = '0;
    check("sat_reach_ffff", fail_count, 16'hFFFF);
    rd(BASE + 8'd1, rd_val);
    check("sat_read_lo", rd_val, 8'hFF);
    rd(BASE + 8'd2, rd_val);
    check("sat_read_hi", rd_val, 8'hFF);
    rd(BASE + 8'd3, rd_val);
    check("sat_check_count_ff", rd_val, 8'hFF);
    wr(2'd2, 8'h11);
    check("sat_hold_ffff", fail_count, 16'hFFFF);
    check("sat_pulse", {check_valid, check_mismatch}, 2'b11);
    rd(BASE + 8'd3, rd_val);
    check("sat_check_count_wrap", rd_val, 8'h00);
    wr(2'd0, 8'h08);
    check("clr_fail_count", fail_count, 16'h0000);
    rd(BASE + 8'd3, rd_val);
    check("clr_check_count", rd_val, 8'h00);
    check("clr_still_run", test_done, 1'b0);

    // Reset during DECIDE wins over the pending verdict
    do_reset();
    wr(2'd1, 8'h5A);
    wr(2'd2, 8'h00);
    check("rdec_fail_count_pre", fail_count, 16'h0001);
    @(negedge clk);
    port_id = BASE; out_port = 8'h04; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; port_id = '0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rdec_no_verdict", {test_passed, test_failed, test_done}, 3'b000);
    check("rdec_fail_count", fail_count, 16'h0000);
    @(negedge clk);
    check("rdec_still_idle", test_done, 1'b0);
    wr(2'd0, 8'h01);
    check("rdec_back_in_run", {test_passed, test_failed, test_done}, 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
